// File: rtl/imm_decode_stage.sv
// imm_decode_stage: RV32I format classifier and immediate builder feeding a 2-entry skid buffer.
module imm_decode_stage #(
    parameter int PC_W = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_imm,
    output logic [PC_W-1:0] out_pc,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);
    localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2;
    localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5, F_X = 3'd7;
    localparam int EW = 32 + PC_W + 4;

    logic [1:0]    state, nxt;
    logic [2:0]    dec_fmt;
    logic [31:0]   dec_imm;
    logic          dec_ill, accept, consume;
    logic [EW-1:0] head, skid, dec;

    always_comb begin
        dec_fmt = F_X;
        dec_ill = 1'b0;
        case (in_instr[6:0])
            7'b0110111, 7'b0010111: dec_fmt = F_U;
            7'b1101111: dec_fmt = F_J;
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: dec_fmt = F_I;
            7'b0100011: dec_fmt = F_S;
            7'b1100011: dec_fmt = F_B;
            7'b0110011: dec_fmt = F_R;
            default: dec_ill = 1'b1;
        endcase
        dec_imm = dec_fmt == F_I ? {{20{in_instr[31]}}, in_instr[31:20]} :
                  dec_fmt == F_S ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]} :
                  dec_fmt == F_B ? {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0} :
                  dec_fmt == F_U ? {in_instr[31:12], 12'b0} :
                  dec_fmt == F_J ? {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0} :
                  32'd0;
    end

    assign dec       = {dec_imm, in_pc, dec_fmt, dec_ill};
    assign out_valid = state != EMPTY;
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;
    assign {out_imm, out_pc, out_fmt, out_illegal} = head;

    always_comb begin
        nxt = flush ? EMPTY :
              state == EMPTY ? (accept ? ONE : EMPTY) :
              state == ONE ? (accept & !consume ? TWO : consume & !accept ? EMPTY : ONE) :
              (consume ? ONE : TWO);
    end

    // head always holds the oldest entry; skid only fills when head is held by backpressure
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            head     <= '0;
            skid     <= '0;
        end else begin
            state    <= nxt;
            in_ready <= nxt != TWO;
            if (!flush) begin
                if (state == TWO && consume) head <= skid;
                else if (accept && (state == EMPTY || consume)) head <= dec;
                if (accept && state == ONE && !consume) skid <= dec;
            end
        end
    end
endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage: directed vectors with hand-computed immediates, ordering, flush and reset checks.
module tb_imm_decode_stage;
    logic        clock = 1'b0, reset = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] in_instr = '0, in_pc = '0, out_imm, out_pc;
    logic [2:0]  out_fmt;
    int          total = 0, bad = 0;

    imm_decode_stage #(.PC_W(32)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_imm(out_imm), .out_pc(out_pc), .out_fmt(out_fmt),
        .out_illegal(out_illegal)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_t1();
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h40; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_imm", out_imm, 32'hFFFFFFFF);
        chk("t1_fmt", {29'd0, out_fmt}, 32'd1);
        chk("t1_ill", {31'd0, out_illegal}, 32'd0);
        chk("t1_pc", out_pc, 32'h40);
        step();
        chk("t1_drain", {31'd0, out_valid}, 32'd0);
    endtask

    logic [31:0] vi [6] = '{32'hFE20AE23, 32'hFE000CE3, 32'h123450B7, 32'hFFDFF0EF, 32'h00000000, 32'h002081B3};
    logic [31:0] vm [6] = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'hFFFFFFFC, 32'h0, 32'h0};
    logic [2:0]  vf [6] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd0};

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_fmt", {29'd0, out_fmt}, 32'd0);
        reset = 1'b0;
        step();
        run_t1();

        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_instr = vi[i]; in_pc = 32'h1000 + 32'(4 * i);
            step();
            chk($sformatf("t2_valid%0d", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("t2_ready%0d", i), {31'd0, in_ready}, 32'd1);
            chk($sformatf("t2_imm%0d", i), out_imm, vm[i]);
            chk($sformatf("t2_fmt%0d", i), {29'd0, out_fmt}, {29'd0, vf[i]});
            chk($sformatf("t2_ill%0d", i), {31'd0, out_illegal}, {31'd0, vf[i] == 3'd7});
            chk($sformatf("t2_pc%0d", i), out_pc, 32'h1000 + 32'(4 * i));
        end
        in_valid = 1'b0;
        step();
        chk("t2_empty", {31'd0, out_valid}, 32'd0);

        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h100;
        step();
        chk("t4_one_ready", {31'd0, in_ready}, 32'd1);
        in_pc = 32'h104;
        step();
        chk("t4_two_ready", {31'd0, in_ready}, 32'd0);
        chk("t4_hold_pc", out_pc, 32'h100);
        in_pc = 32'h108;
        step();
        chk("t4_stall_pc", out_pc, 32'h100);
        chk("t4_stall_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        chk("t4_pc104", out_pc, 32'h104);
        chk("t4_ready_back", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        chk("t4_pc108", out_pc, 32'h108);
        chk("t4_imm", out_imm, 32'd1);
        step();
        chk("t4_empty", {31'd0, out_valid}, 32'd0);

        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h200;
        step();
        in_pc = 32'h204;
        step();
        chk("t5_full", {31'd0, in_ready}, 32'd0);
        flush = 1'b1; out_ready = 1'b1; in_pc = 32'h208;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("t5_no_accept", {31'd0, out_valid}, 32'd0);

        out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h300;
        step();
        in_pc = 32'h304;
        step();
        in_valid = 1'b0;
        chk("t6_full", {31'd0, in_ready}, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("t6_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_ready", {31'd0, in_ready}, 32'd1);
        chk("t6_pc", out_pc, 32'd0);
        step();
        reset = 1'b0;
        step();
        run_t1();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
